// File: rtl/avmm_rr_arbiter.sv
// rtl/avmm_rr_arbiter.sv - round-robin arbiter sharing one Avalon-MM slave among NM masters
// Grant is held for a whole transaction; one transaction in flight at a time.
module avmm_rr_arbiter #(
  parameter int NM        = 2,
  parameter int AW        = 16,
  parameter int DW        = 64,
  parameter int MAX_BURST = 1,
  localparam int BCW      = $clog2(MAX_BURST),
  localparam int BW       = BCW + 1,
  localparam int GW       = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NM*AW-1:0]    m_address,
  input  logic [NM-1:0]       m_read,
  input  logic [NM-1:0]       m_write,
  input  logic [NM*BW-1:0]    m_burstcount,
  input  logic [NM*DW-1:0]    m_writedata,
  input  logic [NM*DW/8-1:0]  m_byteenable,
  output logic [NM-1:0]       m_waitrequest,
  output logic [DW-1:0]       m_readdata,
  output logic [NM-1:0]       m_readdatavalid,
  output logic [AW-1:0]       s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [BW-1:0]       s_burstcount,
  output logic [DW-1:0]       s_writedata,
  output logic [DW/8-1:0]     s_byteenable,
  input  logic                s_waitrequest,
  input  logic [DW-1:0]       s_readdata,
  input  logic                s_readdatavalid
);

  typedef enum logic [1:0] {IDLE, CMD, RDATA} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_q, last_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic          wr_started_q, wr_started_d;

  logic [AW-1:0]   addr_a [NM];
  logic [BW-1:0]   bc_a   [NM];
  logic [DW-1:0]   wdata_a[NM];
  logic [DW/8-1:0] be_a   [NM];

  for (genvar i = 0; i < NM; i++) begin : g_unpack
    assign addr_a[i]  = m_address[i*AW +: AW];
    assign bc_a[i]    = m_burstcount[i*BW +: BW];
    assign wdata_a[i] = m_writedata[i*DW +: DW];
    assign be_a[i]    = m_byteenable[i*DW/8 +: DW/8];
  end

  logic          g_read, g_write;
  logic [BW-1:0] g_bc_eff;
  logic          any_req;
  logic [GW-1:0] pick;

  assign g_read     = m_read[grant_q];
  assign g_write    = m_write[grant_q];
  assign g_bc_eff   = (bc_a[grant_q] == '0) ? BW'(1) : bc_a[grant_q];
  assign any_req    = |(m_read | m_write);
  assign m_readdata = s_readdata;

  // First requester after the last winner, wrapping modulo NM.
  always_comb begin : p_pick
    int  idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    pick  = last_q;
    for (int k = 1; k <= NM; k++) begin
      idx = (int'(last_q) + k) % NM;
      if (!found && (m_read[idx] || m_write[idx])) begin
        pick  = GW'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    last_d          = last_q;
    cnt_d           = cnt_q;
    wr_started_d    = wr_started_q;
    m_waitrequest   = '1;
    m_readdatavalid = '0;
    s_read          = 1'b0;
    s_write         = 1'b0;
    s_address       = '0;
    s_burstcount    = '0;
    s_writedata     = '0;
    s_byteenable    = '0;
    case (state_q)
      IDLE: begin
        wr_started_d = 1'b0;
        if (any_req) begin
          grant_d = pick;
          last_d  = pick;
          state_d = CMD;
        end
      end
      CMD: begin
        s_address              = addr_a[grant_q];
        s_burstcount           = bc_a[grant_q];
        s_writedata            = wdata_a[grant_q];
        s_byteenable           = be_a[grant_q];
        s_read                 = g_read & ~wr_started_q;
        s_write                = g_write;
        m_waitrequest[grant_q] = s_waitrequest;
        if (s_read && !s_waitrequest) begin
          cnt_d   = g_bc_eff;
          state_d = RDATA;
        end else if (s_write && !s_waitrequest) begin
          if (!wr_started_q) begin
            wr_started_d = 1'b1;
            cnt_d        = g_bc_eff - BW'(1);
            if (g_bc_eff == BW'(1)) state_d = IDLE;
          end else begin
            cnt_d = cnt_q - BW'(1);
            if (cnt_q == BW'(1)) state_d = IDLE;
          end
        end else if (!wr_started_q && !g_read && !g_write) begin
          // Request withdrawn before the slave took it: release without access.
          state_d = IDLE;
        end
      end
      RDATA: begin
        m_readdatavalid[grant_q] = s_readdatavalid;
        if (s_readdatavalid) begin
          cnt_d = cnt_q - BW'(1);
          if (cnt_q == BW'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_q       <= GW'(NM - 1);
      cnt_q        <= '0;
      wr_started_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      wr_started_q <= wr_started_d;
    end
  end

endmodule

// File: tb/tb_avmm_rr_arbiter.sv
// tb/tb_avmm_rr_arbiter.sv - directed scenarios plus randomized run against a transaction-level model
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_avmm_rr_arbiter;

  localparam int NM = 2, AW = 16, DW = 64, MB = 4, BW = 3;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NM*AW-1:0]  m_address;
  logic [NM-1:0]     m_read, m_write;
  logic [NM*BW-1:0]  m_burstcount;
  logic [NM*DW-1:0]  m_writedata;
  logic [NM*DW/8-1:0] m_byteenable;
  logic [NM-1:0]     m_waitrequest;
  logic [DW-1:0]     m_readdata;
  logic [NM-1:0]     m_readdatavalid;
  logic [AW-1:0]     s_address;
  logic              s_read, s_write;
  logic [BW-1:0]     s_burstcount;
  logic [DW-1:0]     s_writedata;
  logic [DW/8-1:0]   s_byteenable;
  logic              s_waitrequest;
  logic [DW-1:0]     s_readdata;
  logic              s_readdatavalid;

  int checks = 0;
  int errors = 0;

  avmm_rr_arbiter #(.NM(NM), .AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset_n(reset_n),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_burstcount(m_burstcount), .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_burstcount(s_burstcount), .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int i, input logic [AW-1:0] a, input logic [BW-1:0] bc,
                       input logic [DW-1:0] d);
    m_address[i*AW +: AW]      = a;
    m_burstcount[i*BW +: BW]   = bc;
    m_writedata[i*DW +: DW]    = d;
    m_byteenable[i*DW/8 +: DW/8] = '1;
  endtask

  function automatic int eff(input int bc);
    return (bc == 0) ? 1 : bc;
  endfunction

  function automatic logic [DW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    m_read = 2'b11; m_write = '0;
    m_address = '0; m_burstcount = '0; m_writedata = '0; m_byteenable = '0;
    s_waitrequest = 1'b0; s_readdata = '0; s_readdatavalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (m_waitrequest !== 2'b11) begin errors++; $display("FAIL reset_waitreq got=%b exp=11", m_waitrequest); end
      checks++; if (s_read !== 1'b0 || s_write !== 1'b0) begin errors++; $display("FAIL reset_srw got=%b%b exp=00", s_read, s_write); end
      checks++; if (m_readdatavalid !== 2'b00) begin errors++; $display("FAIL reset_rdv got=%b exp=00", m_readdatavalid); end
      checks++; if (s_address !== '0) begin errors++; $display("FAIL reset_addr got=%h exp=0", s_address); end
      if (c < 2) tick();
    end
    tick();
    m_read = '0;
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (m_waitrequest !== 2'b11) begin errors++; $display("FAIL post_reset_waitreq got=%b exp=11", m_waitrequest); end
  endtask

  task automatic test_single_read();
    int pulses = 0;
    tick();
    set_m(1, 16'h0010, 3'd1, '0);
    m_read = 2'b10; s_waitrequest = 1'b1;
    @(negedge clk);
    checks++; if (s_read !== 1'b0) begin errors++; $display("FAIL sr_arb_cycle s_read got=%b exp=0", s_read); end
    for (int w = 0; w < 2; w++) begin
      tick();
      @(negedge clk);
      checks++; if (s_read !== 1'b1 || s_address !== 16'h0010) begin errors++; $display("FAIL sr_cmd_wait s_read=%b addr=%h exp 1/0010", s_read, s_address); end
      checks++; if (m_waitrequest !== 2'b11) begin errors++; $display("FAIL sr_waitreq got=%b exp=11", m_waitrequest); end
    end
    tick();
    s_waitrequest = 1'b0;
    @(negedge clk);
    checks++; if (s_read !== 1'b1 || m_waitrequest !== 2'b01) begin errors++; $display("FAIL sr_accept s_read=%b waitreq=%b exp 1/01", s_read, m_waitrequest); end
    tick();
    m_read = '0; s_readdatavalid = 1'b1; s_readdata = 64'hDEAD;
    @(negedge clk);
    if (m_readdatavalid == 2'b10) pulses++;
    checks++; if (m_readdatavalid !== 2'b10 || m_readdata !== 64'hDEAD) begin errors++; $display("FAIL sr_data rdv=%b data=%h exp 10/dead", m_readdatavalid, m_readdata); end
    checks++; if (s_read !== 1'b0) begin errors++; $display("FAIL sr_rdata_sread got=%b exp=0", s_read); end
    tick();
    s_readdatavalid = 1'b0;
    @(negedge clk);
    if (m_readdatavalid != 2'b00) pulses++;
    checks++; if (pulses !== 1 || m_waitrequest !== 2'b11) begin errors++; $display("FAIL sr_once pulses=%0d waitreq=%b exp 1/11", pulses, m_waitrequest); end
  endtask

  task automatic test_round_robin();
    logic [8:0]    exp_sread;
    logic [1:0]    exp_wr [9];
    logic [1:0]    exp_rdv[9];
    logic [AW-1:0] exp_addr[9];
    logic          nxt;
    exp_sread = 9'b010010010;
    exp_wr    = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b01, 2'b11, 2'b11, 2'b10, 2'b11};
    exp_rdv   = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01};
    exp_addr  = '{16'h0, 16'h0100, 16'h0, 16'h0, 16'h0200, 16'h0, 16'h0, 16'h0100, 16'h0};
    tick();
    set_m(0, 16'h0100, 3'd1, '0);
    set_m(1, 16'h0200, 3'd1, '0);
    m_read = 2'b11; s_waitrequest = 1'b0; s_readdatavalid = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      checks++; if (s_read !== exp_sread[8-k]) begin errors++; $display("FAIL rr_sread[%0d] got=%b exp=%b", k, s_read, exp_sread[8-k]); end
      checks++; if (m_waitrequest !== exp_wr[k]) begin errors++; $display("FAIL rr_waitreq[%0d] got=%b exp=%b", k, m_waitrequest, exp_wr[k]); end
      checks++; if (m_readdatavalid !== exp_rdv[k]) begin errors++; $display("FAIL rr_rdv[%0d] got=%b exp=%b", k, m_readdatavalid, exp_rdv[k]); end
      if (exp_sread[8-k]) begin
        checks++; if (s_address !== exp_addr[k]) begin errors++; $display("FAIL rr_addr[%0d] got=%h exp=%h", k, s_address, exp_addr[k]); end
      end
      nxt = s_read & ~s_waitrequest;
      if (k < 8) begin
        tick();
        s_readdatavalid = nxt;
        s_readdata = rnd64();
      end
    end
  endtask

  task automatic test_write_burst();
    logic [DW-1:0] beat[4];
    int b = 0;
    int cyc = 0;
    for (int i = 0; i < 4; i++) beat[i] = rnd64();
    tick();
    m_read = '0; s_readdatavalid = 1'b0; s_waitrequest = 1'b0;
    set_m(0, 16'h0300, 3'd4, beat[0]);
    m_write = 2'b01;
    @(negedge clk);
    checks++; if (s_write !== 1'b0) begin errors++; $display("FAIL wb_arb s_write got=%b exp=0", s_write); end
    tick();
    set_m(1, 16'h0400, 3'd1, 64'h1111);
    m_write = 2'b11;
    while (b < 4 && cyc < 20) begin
      s_waitrequest = (cyc == 1);
      @(negedge clk);
      checks++; if (m_waitrequest[1] !== 1'b1) begin errors++; $display("FAIL wb_m1_blocked cyc=%0d got=%b exp=1", cyc, m_waitrequest[1]); end
      checks++; if (s_write !== 1'b1 || s_address !== 16'h0300) begin errors++; $display("FAIL wb_cmd cyc=%0d s_write=%b addr=%h exp 1/0300", cyc, s_write, s_address); end
      if (s_write && !s_waitrequest) begin
        checks++; if (s_writedata !== beat[b]) begin errors++; $display("FAIL wb_data beat=%0d got=%h exp=%h", b, s_writedata, beat[b]); end
        b++;
      end
      tick();
      cyc++;
      if (b < 4) m_writedata[0 +: DW] = beat[b];
      else m_write[0] = 1'b0;
    end
    s_waitrequest = 1'b0;
    checks++; if (b !== 4 || cyc !== 5) begin errors++; $display("FAIL wb_beats beats=%0d cycles=%0d exp 4/5", b, cyc); end
    @(negedge clk);
    checks++; if (s_write !== 1'b0 || m_waitrequest !== 2'b11) begin errors++; $display("FAIL wb_idle s_write=%b waitreq=%b exp 0/11", s_write, m_waitrequest); end
    tick();
    @(negedge clk);
    checks++; if (s_write !== 1'b1 || s_address !== 16'h0400 || m_waitrequest !== 2'b01) begin errors++; $display("FAIL wb_m1_grant s_write=%b addr=%h waitreq=%b exp 1/0400/01", s_write, s_address, m_waitrequest); end
    tick();
    m_write = '0;
    @(negedge clk);
    checks++; if (m_waitrequest !== 2'b11) begin errors++; $display("FAIL wb_end waitreq got=%b exp=11", m_waitrequest); end
  endtask

  task automatic test_read_burst();
    logic [5:0] pat;
    logic [DW-1:0] d;
    int got = 0;
    pat = 6'b101101;
    tick();
    set_m(1, 16'h0500, 3'd4, '0);
    m_read = 2'b10;
    @(negedge clk);
    checks++; if (s_read !== 1'b0) begin errors++; $display("FAIL rb_arb s_read got=%b exp=0", s_read); end
    tick();
    @(negedge clk);
    checks++; if (s_read !== 1'b1 || s_address !== 16'h0500 || s_burstcount !== 3'd4 || m_waitrequest !== 2'b01) begin errors++; $display("FAIL rb_cmd s_read=%b addr=%h bc=%0d waitreq=%b exp 1/0500/4/01", s_read, s_address, s_burstcount, m_waitrequest); end
    tick();
    set_m(0, 16'h0600, 3'd1, '0);
    m_read = 2'b01;
    for (int k = 0; k < 6; k++) begin
      d = rnd64();
      s_readdatavalid = pat[5-k];
      s_readdata = d;
      @(negedge clk);
      checks++; if (m_readdatavalid !== (pat[5-k] ? 2'b10 : 2'b00)) begin errors++; $display("FAIL rb_rdv[%0d] got=%b exp=%b", k, m_readdatavalid, pat[5-k] ? 2'b10 : 2'b00); end
      checks++; if (m_waitrequest !== 2'b11 || s_read !== 1'b0) begin errors++; $display("FAIL rb_block[%0d] waitreq=%b s_read=%b exp 11/0", k, m_waitrequest, s_read); end
      if (pat[5-k]) begin
        got++;
        checks++; if (m_readdata !== d) begin errors++; $display("FAIL rb_data[%0d] got=%h exp=%h", k, m_readdata, d); end
      end
      tick();
    end
    s_readdatavalid = 1'b0;
    @(negedge clk);
    checks++; if (got !== 4 || s_read !== 1'b0 || m_waitrequest !== 2'b11) begin errors++; $display("FAIL rb_idle beats=%0d s_read=%b waitreq=%b exp 4/0/11", got, s_read, m_waitrequest); end
    tick();
    @(negedge clk);
    checks++; if (s_read !== 1'b1 || s_address !== 16'h0600 || m_waitrequest !== 2'b10) begin errors++; $display("FAIL rb_m0_grant s_read=%b addr=%h waitreq=%b exp 1/0600/10", s_read, s_address, m_waitrequest); end
    tick();
    m_read = '0; s_readdatavalid = 1'b1;
    @(negedge clk);
    checks++; if (m_readdatavalid !== 2'b01) begin errors++; $display("FAIL rb_m0_data rdv=%b exp=01", m_readdatavalid); end
  endtask

  task automatic test_reset_rdata();
    tick();
    s_readdatavalid = 1'b0; s_waitrequest = 1'b0;
    set_m(0, 16'h0700, 3'd4, '0);
    m_read = 2'b01;
    @(negedge clk);
    tick();
    @(negedge clk);
    checks++; if (s_read !== 1'b1 || s_address !== 16'h0700) begin errors++; $display("FAIL rr6_cmd s_read=%b addr=%h exp 1/0700", s_read, s_address); end
    for (int k = 0; k < 2; k++) begin
      tick();
      m_read = '0; s_readdatavalid = 1'b1;
      @(negedge clk);
      checks++; if (m_readdatavalid !== 2'b01) begin errors++; $display("FAIL rr6_beat[%0d] rdv=%b exp=01", k, m_readdatavalid); end
    end
    tick();
    reset_n = 1'b0;
    @(negedge clk);
    checks++; if (m_readdatavalid !== 2'b00 || m_waitrequest !== 2'b11) begin errors++; $display("FAIL rr6_in_reset rdv=%b waitreq=%b exp 00/11", m_readdatavalid, m_waitrequest); end
    tick();
    reset_n = 1'b1;
    set_m(0, 16'h0700, 3'd1, '0);
    set_m(1, 16'h0800, 3'd1, '0);
    m_read = 2'b11;
    @(negedge clk);
    checks++; if (m_readdatavalid !== 2'b00 || s_read !== 1'b0) begin errors++; $display("FAIL rr6_stray rdv=%b s_read=%b exp 00/0", m_readdatavalid, s_read); end
    tick();
    s_readdatavalid = 1'b0;
    @(negedge clk);
    checks++; if (s_address !== 16'h0700 || m_waitrequest !== 2'b10) begin errors++; $display("FAIL rr6_rearb addr=%h waitreq=%b exp 0700/10", s_address, m_waitrequest); end
    tick();
    m_read = 2'b10; s_readdatavalid = 1'b1;
    @(negedge clk);
    checks++; if (m_readdatavalid !== 2'b01) begin errors++; $display("FAIL rr6_m0_data rdv=%b exp=01", m_readdatavalid); end
    tick();
    s_readdatavalid = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    checks++; if (s_address !== 16'h0800 || m_waitrequest !== 2'b01) begin errors++; $display("FAIL rr6_m1_next addr=%h waitreq=%b exp 0800/01", s_address, m_waitrequest); end
    tick();
    m_read = '0;
    @(negedge clk);
  endtask

  // Masters and slave are random agents; the model knows only who owns the bus and how many beats remain.
  task automatic test_random();
    int owner = -1, last = NM - 1, left = 0, total = 0, done_b = 0;
    bit rd_phase = 0, started = 0;
    int mst[NM], mleft[NM];
    logic [AW-1:0] na[NM];
    int nbc[NM];
    logic [DW-1:0] nd[NM];
    int pend = 0, completed = 0;
    logic [1:0] ewr, erdv;
    logic esr, esw, cmd_own;
    for (int i = 0; i < NM; i++) begin mst[i] = 0; mleft[i] = 0; na[i] = '0; nbc[i] = 1; nd[i] = '0; end
    tick();
    reset_n = 1'b0;
    m_read = '0; m_write = '0; s_waitrequest = 1'b0; s_readdatavalid = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      ewr = 2'b11; erdv = 2'b00; esr = 1'b0; esw = 1'b0; cmd_own = 1'b0;
      if (owner >= 0 && !rd_phase) begin
        cmd_own = 1'b1;
        esr = m_read[owner] && !started;
        esw = m_write[owner];
        ewr[owner] = s_waitrequest;
      end else if (owner >= 0) begin
        erdv[owner] = s_readdatavalid;
      end
      checks++; if (m_waitrequest !== ewr) begin errors++; $display("FAIL rnd_waitreq cyc=%0d got=%b exp=%b", cyc, m_waitrequest, ewr); end
      checks++; if (s_read !== esr || s_write !== esw) begin errors++; $display("FAIL rnd_srw cyc=%0d got=%b%b exp=%b%b", cyc, s_read, s_write, esr, esw); end
      checks++; if (m_readdatavalid !== erdv) begin errors++; $display("FAIL rnd_rdv cyc=%0d got=%b exp=%b", cyc, m_readdatavalid, erdv); end
      checks++; if (m_readdata !== s_readdata) begin errors++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, m_readdata, s_readdata); end
      if (cmd_own && (esr || esw)) begin
        checks++;
        if (s_address !== m_address[owner*AW +: AW] || s_burstcount !== m_burstcount[owner*BW +: BW] ||
            s_writedata !== m_writedata[owner*DW +: DW] || s_byteenable !== m_byteenable[owner*DW/8 +: DW/8]) begin
          errors++; $display("FAIL rnd_route cyc=%0d owner=%0d addr=%h exp=%h", cyc, owner, s_address, m_address[owner*AW +: AW]);
        end
      end
      if (owner < 0) begin
        for (int k = 1; k <= NM; k++) begin
          if (owner < 0 && (m_read[(last + k) % NM] || m_write[(last + k) % NM])) begin
            owner = (last + k) % NM;
          end
        end
        if (owner >= 0) begin last = owner; rd_phase = 0; started = 0; end
      end else if (!rd_phase) begin
        if (esr && !s_waitrequest) begin
          rd_phase = 1; left = eff(int'(m_burstcount[owner*BW +: BW]));
        end else if (esw && !s_waitrequest) begin
          if (!started) begin started = 1; total = eff(int'(m_burstcount[owner*BW +: BW])); done_b = 0; end
          done_b++;
          if (done_b == total) owner = -1;
        end else if (!started && !m_read[owner] && !m_write[owner]) begin
          owner = -1;
        end
      end else if (s_readdatavalid) begin
        left--;
        if (left == 0) owner = -1;
      end
      if (s_read && !s_waitrequest) pend += eff(int'(s_burstcount));
      if (s_readdatavalid) pend--;
      for (int i = 0; i < NM; i++) begin
        case (mst[i])
          1: if (!m_waitrequest[i]) begin mst[i] = 2; mleft[i] = eff(nbc[i]); end
             else if ($urandom_range(15) == 0) mst[i] = 0;
          2: if (m_readdatavalid[i]) begin
               mleft[i]--;
               if (mleft[i] == 0) begin mst[i] = 0; completed++; end
             end
          3: if (!m_waitrequest[i]) begin
               mleft[i]--; nd[i] = rnd64();
               if (mleft[i] == 0) begin mst[i] = 0; completed++; end
             end
          default: if ($urandom_range(2) == 0) begin
               na[i] = 16'($urandom); nbc[i] = $urandom_range(MB); nd[i] = rnd64();
               mleft[i] = eff(nbc[i]);
               mst[i] = ($urandom_range(1) == 0) ? 1 : 3;
             end
        endcase
      end
      tick();
      for (int i = 0; i < NM; i++) begin
        set_m(i, na[i], 3'(nbc[i]), nd[i]);
        m_byteenable[i*DW/8 +: DW/8] = 8'($urandom);
        m_read[i]  = (mst[i] == 1);
        m_write[i] = (mst[i] == 3);
      end
      s_waitrequest   = ($urandom_range(2) == 0);
      s_readdatavalid = (pend > 0) && ($urandom_range(1) == 0);
      s_readdata      = rnd64();
    end
    checks++; if (completed < 50) begin errors++; $display("FAIL rnd_activity completed=%0d exp>=50", completed); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_burst();
    test_read_burst();
    test_reset_rdata();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
